// File: rtl/uart_rx_buffered.sv
//------------------------------------------------------------------------------
// Module : uart_rx_buffered
// Brief  : 8N1 UART receiver (16x oversampled) feeding a one-byte holding buffer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_rx_buffered #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rd_uart,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            frame_err,
  output logic            overrun_err
);

  // Tick counter must reach both 15 (data bits) and SB_TICK-1 (stop bit).
  localparam int c_S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int c_N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic            r_rx_meta;
  logic            r_rx_s;
  state_t          r_state;
  logic [c_S_W-1:0] r_s;
  logic [c_N_W-1:0] r_n;
  logic [DBIT-1:0] r_b;

  state_t          w_state_nx;
  logic [c_S_W-1:0] w_s_nx;
  logic [c_N_W-1:0] w_n_nx;
  logic [DBIT-1:0] w_b_nx;
  logic            w_done;
  logic            w_ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_s     <= w_s_nx;
      r_n     <= w_n_nx;
      r_b     <= w_b_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_n_nx     = r_n;
    w_b_nx     = r_b;
    w_done     = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_nx = START;
          w_s_nx     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s == c_S_W'(7)) begin
            if (!r_rx_s) begin
              w_state_nx = DATA;
              w_s_nx     = '0;
              w_n_nx     = '0;
            end else begin
              w_state_nx = IDLE;
            end
          end else begin
            w_s_nx = r_s + c_S_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == c_S_W'(15)) begin
            w_s_nx = '0;
            w_b_nx = {r_rx_s, r_b[DBIT-1:1]};
            if (r_n == c_N_W'(DBIT - 1)) begin
              w_state_nx = STOP;
            end else begin
              w_n_nx = r_n + c_N_W'(1);
            end
          end else begin
            w_s_nx = r_s + c_S_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (r_s == c_S_W'(SB_TICK - 1)) begin
            w_state_nx = IDLE;
            w_done     = r_rx_s;
            w_ferr     = ~r_rx_s;
          end else begin
            w_s_nx = r_s + c_S_W'(1);
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // A pop in the done cycle frees the slot, so the new byte loads without overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= '0;
      rx_empty    <= 1'b1;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= w_ferr;
      overrun_err <= 1'b0;
      if (w_done) begin
        if (rx_empty || rd_uart) begin
          r_data   <= r_b;
          rx_empty <= 1'b0;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rd_uart && !rx_empty) begin
        rx_empty <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
//------------------------------------------------------------------------------
// Module : tb_uart_rx_buffered
// Brief  : Self-checking bench for uart_rx_buffered against a byte-level model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_buffered;

  localparam int c_BIT_CLK     = 64;
  localparam int c_FRAME_TICKS = 8 + 16 * 8 + 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rd_uart = 1'b0;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       frame_err;
  logic       overrun_err;

  logic [1:0] tdiv = 2'd0;

  logic [7:0] m_data = 8'h00;
  bit         m_empty = 1'b1;
  int         m_fe = 0;
  int         m_ov = 0;
  int         obs_fe = 0;
  int         obs_ov = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  uart_rx_buffered #(.DBIT(8), .SB_TICK(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_tick     (s_tick),
    .rx         (rx),
    .rd_uart    (rd_uart),
    .r_data     (r_data),
    .rx_empty   (rx_empty),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    tdiv   = tdiv + 2'd1;
    s_tick = (tdiv == 2'd0);
    if (frame_err)   obs_fe++;
    if (overrun_err) obs_ov++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] d, input bit stop_ok, input int abort_bit);
    rx = 1'b0;
    wait_cyc(c_BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (abort_bit == i) begin
        wait_cyc(c_BIT_CLK / 2);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        rx = 1'b1;
        return;
      end
      wait_cyc(c_BIT_CLK);
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_cyc(c_BIT_CLK);
    end else begin
      // Low only through the sample point so the re-armed receiver rejects it as a glitch.
      rx = 1'b0;
      wait_cyc(48);
      rx = 1'b1;
      wait_cyc(c_BIT_CLK - 48);
    end
    rx = 1'b1;
  endtask

  // Counts ticks from the start edge to find the clk edge that completes the frame.
  task automatic predict(input logic [7:0] d, input bit stop_ok, input bit pop_done);
    int pe;
    int ticks;
    bit exp_fe;
    bit exp_ov;
    pe = 1;
    ticks = 0;
    while (ticks < c_FRAME_TICKS) begin
      wait_cyc(1);
      pe++;
      if (pe >= 4 && s_tick) ticks++;
    end
    check("pre_done_empty", {31'd0, rx_empty}, {31'd0, m_empty});
    rd_uart = pop_done;
    exp_fe = !stop_ok;
    exp_ov = 1'b0;
    if (stop_ok) begin
      if (m_empty || pop_done) begin
        m_data  = d;
        m_empty = 1'b0;
      end else begin
        exp_ov = 1'b1;
      end
    end else if (pop_done) begin
      m_empty = 1'b1;
    end
    if (exp_fe) m_fe++;
    if (exp_ov) m_ov++;
    wait_cyc(1);
    rd_uart = 1'b0;
    check("done_data", {24'd0, r_data}, {24'd0, m_data});
    check("done_empty", {31'd0, rx_empty}, {31'd0, m_empty});
    check("done_frame_err", {31'd0, frame_err}, {31'd0, exp_fe});
    check("done_overrun", {31'd0, overrun_err}, {31'd0, exp_ov});
    wait_cyc(1);
    check("frame_err_1clk", {31'd0, frame_err}, 32'd0);
    check("overrun_1clk", {31'd0, overrun_err}, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit stop_ok, input bit pop_done,
                           input int abort_bit, input int gap);
    fork
      drive(d, stop_ok, abort_bit);
      begin
        if (abort_bit < 0) predict(d, stop_ok, pop_done);
      end
    join
    if (abort_bit >= 0) begin
      m_data  = 8'h00;
      m_empty = 1'b1;
      check("abort_data", {24'd0, r_data}, 32'd0);
      check("abort_empty", {31'd0, rx_empty}, 32'd1);
      check("abort_ferr", {31'd0, frame_err}, 32'd0);
      check("abort_ovr", {31'd0, overrun_err}, 32'd0);
    end
    wait_cyc(gap);
  endtask

  task automatic pop();
    check("pop_pre_data", {24'd0, r_data}, {24'd0, m_data});
    rd_uart = 1'b1;
    wait_cyc(1);
    rd_uart = 1'b0;
    m_empty = 1'b1;
    check("pop_empty", {31'd0, rx_empty}, 32'd1);
    check("pop_hold_data", {24'd0, r_data}, {24'd0, m_data});
  endtask

  initial begin
    logic [7:0] rb;
    wait_cyc(3);
    check("rst_data", {24'd0, r_data}, 32'd0);
    check("rst_empty", {31'd0, rx_empty}, 32'd1);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun_err}, 32'd0);
    reset = 1'b0;
    wait_cyc(5);

    run_frame(8'h01, 1'b1, 1'b0, -1, 0);
    pop();
    run_frame(8'h04, 1'b1, 1'b0, -1, 0);
    pop();
    run_frame(8'h80, 1'b1, 1'b0, -1, 0);
    pop();

    rx = 1'b0;
    wait_cyc(8);
    rx = 1'b1;
    wait_cyc(80);
    check("glitch_empty", {31'd0, rx_empty}, 32'd1);
    check("glitch_ferr_cnt", obs_fe, m_fe);
    run_frame(8'h55, 1'b1, 1'b0, -1, 0);
    pop();

    run_frame(8'hA5, 1'b0, 1'b0, -1, 40);

    run_frame(8'h11, 1'b1, 1'b0, -1, 0);
    run_frame(8'h22, 1'b1, 1'b0, -1, 0);
    pop();

    run_frame(8'h33, 1'b1, 1'b0, -1, 0);
    run_frame(8'h44, 1'b1, 1'b1, -1, 0);

    run_frame(8'h7E, 1'b1, 1'b0, 3, 700);
    check("post_abort_empty", {31'd0, rx_empty}, 32'd1);
    run_frame(8'h0F, 1'b1, 1'b0, -1, 0);
    pop();

    for (int k = 0; k < 10; k++) begin
      rb = 8'($urandom);
      run_frame(rb, 1'b1, ($urandom_range(0, 3) == 0), -1, $urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1) pop();
    end

    wait_cyc(10);
    check("total_frame_err", obs_fe, m_fe);
    check("total_overrun", obs_ov, m_ov);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
